// File: rtl/syzygy_dac_sweep_dds.sv
// ----------------------------------------------------------------------------
// syzygy_dac_sweep_dds
//
// Multi-channel DDS waveform generator with per-channel start/stop frequency
// sweeps (chirps), feeding offset-binary samples to the SYZYGY DAC PHY.
//
// Ports
//   clk         system clock
//   reset       asynchronous, active-high reset
//   dis_out     forces every output to mid-scale; accumulators keep running
//   dac_ready   DAC init complete; outputs held at mid-scale while low
//   cfg_wr      one-cycle config write strobe. There is no back-pressure: a
//               write is accepted on every cycle cfg_wr is high. Out-of-range
//               channel or address values are dropped.
//   cfg_ch      target channel
//   cfg_addr    0 FSTART, 1 FSTOP, 2 FSTEP, 3 DWELL, 4 CTRL
//   cfg_data    write data (CTRL: [1:0] mode, [2] sweep_en, [3] loop,
//               [16 +: DATA_W] ampl)
//   start       per-channel start/restart pulse (wins over stop)
//   stop        per-channel stop pulse
//   data        samples, channel n at [n*DATA_W +: DATA_W]
//   running     channel not IDLE
//   sweep_done  one-cycle pulse when a sweep reaches FSTOP
//   state_dbg   per-channel FSM state, 2 bits per channel
//               (0 IDLE, 1 RUN, 2 SWEEP, 3 HOLD)
//
// Optional: define SYZYGY_DAC_DITHER_EN to add a 1-LSB LFSR dither to
// active channels.
// ----------------------------------------------------------------------------
module syzygy_dac_sweep_dds #(
   parameter int NUM_CH = 2,
   parameter int CH_AW  = 1,
   parameter int DATA_W = 12,
   parameter int ACC_W  = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     dis_out,
   input  logic                     dac_ready,
   input  logic                     cfg_wr,
   input  logic [CH_AW-1:0]         cfg_ch,
   input  logic [2:0]               cfg_addr,
   input  logic [ACC_W-1:0]         cfg_data,
   input  logic [NUM_CH-1:0]        start,
   input  logic [NUM_CH-1:0]        stop,
   output logic [NUM_CH*DATA_W-1:0] data,
   output logic [NUM_CH-1:0]        running,
   output logic [NUM_CH-1:0]        sweep_done,
   output logic [2*NUM_CH-1:0]      state_dbg
);

   localparam int PW = 2*DATA_W + 2;
   localparam logic [DATA_W-1:0] MID = {1'b1, {(DATA_W-1){1'b0}}};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_SWEEP = 2'd2,
      ST_HOLD  = 2'd3
   } state_e;

   logic gate;
   assign gate = dis_out | ~dac_ready;

   logic dith;
`ifdef SYZYGY_DAC_DITHER_EN
   // Fibonacci LFSR, taps 16,14,13,11, shared by all channels.
   logic [15:0] lfsr_q, lfsr_d;
   always_comb lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   always_ff @(posedge clk or posedge reset) begin
      if (reset) lfsr_q <= 16'hACE1;
      else       lfsr_q <= lfsr_d;
   end
   assign dith = lfsr_q[0];
`else
   assign dith = 1'b0;
`endif

   for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
      // Shadow registers written by the host.
      logic [ACC_W-1:0]  fstart_s_q, fstop_s_q, fstep_s_q, dwell_s_q;
      logic [1:0]        mode_s_q;
      logic              sweep_s_q, loop_s_q;
      logic [DATA_W-1:0] ampl_s_q;
      // Active copies, latched on start.
      logic [ACC_W-1:0]  fstart_q, fstop_q, fstep_q, dwell_q;
      logic [1:0]        mode_q;
      logic              loop_q;
      logic [DATA_W-1:0] ampl_q;
      // Channel state.
      state_e            state_q, state_d;
      logic [ACC_W-1:0]  acc_q, acc_d, inc_q, inc_d, dcnt_q, dcnt_d;
      logic              done_q, done_d;
      logic [ACC_W:0]    nxt;
      logic              wr;
      // Waveform pipeline.
      logic [DATA_W-1:0] p, wave_d, wave_q, out_d, data_q;
      logic              act_q;
      logic signed [DATA_W:0] s;
      logic signed [PW-1:0]   prod, tot;

      assign wr = cfg_wr && (cfg_ch == CH_AW'(n));

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            fstart_s_q <= '0; fstop_s_q <= '0; fstep_s_q <= '0; dwell_s_q <= '0;
            mode_s_q   <= '0; sweep_s_q <= 1'b0; loop_s_q <= 1'b0; ampl_s_q <= '0;
         end else if (wr) begin
            case (cfg_addr)
               3'd0: fstart_s_q <= cfg_data;
               3'd1: fstop_s_q  <= cfg_data;
               3'd2: fstep_s_q  <= cfg_data;
               3'd3: dwell_s_q  <= cfg_data;
               3'd4: begin
                  mode_s_q  <= cfg_data[1:0];
                  sweep_s_q <= cfg_data[2];
                  loop_s_q  <= cfg_data[3];
                  ampl_s_q  <= cfg_data[16 +: DATA_W];
               end
               default: ;
            endcase
         end
      end

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            fstart_q <= '0; fstop_q <= '0; fstep_q <= '0; dwell_q <= '0;
            mode_q   <= '0; loop_q  <= 1'b0; ampl_q <= '0;
         end else if (start[n]) begin
            fstart_q <= fstart_s_q; fstop_q <= fstop_s_q;
            fstep_q  <= fstep_s_q;  dwell_q <= dwell_s_q;
            mode_q   <= mode_s_q;   loop_q  <= loop_s_q; ampl_q <= ampl_s_q;
         end
      end

      always_comb begin
         state_d = state_q;
         acc_d   = acc_q;
         inc_d   = inc_q;
         dcnt_d  = dcnt_q;
         done_d  = 1'b0;
         // One extra bit so a wrap past 2^ACC_W counts as reaching FSTOP.
         nxt     = {1'b0, inc_q} + {1'b0, fstep_q};
         if (start[n]) begin
            // Shadows are latched this same edge, so read them directly.
            acc_d   = '0;
            inc_d   = fstart_s_q;
            dcnt_d  = '0;
            state_d = sweep_s_q ? ST_SWEEP : ST_RUN;
         end else if (stop[n]) begin
            state_d = ST_IDLE;
         end else begin
            case (state_q)
               ST_RUN, ST_HOLD: acc_d = acc_q + inc_q;
               ST_SWEEP: begin
                  acc_d = acc_q + inc_q;
                  if (dcnt_q == dwell_q) begin
                     dcnt_d = '0;
                     if (nxt[ACC_W] || (nxt[ACC_W-1:0] >= fstop_q)) begin
                        done_d = 1'b1;
                        if (loop_q) begin
                           inc_d = fstart_q;
                        end else begin
                           inc_d   = fstop_q;
                           state_d = ST_HOLD;
                        end
                     end else begin
                        inc_d = nxt[ACC_W-1:0];
                     end
                  end else begin
                     dcnt_d = dcnt_q + ACC_W'(1);
                  end
               end
               default: ;
            endcase
         end
      end

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            inc_q   <= '0;
            dcnt_q  <= '0;
            done_q  <= 1'b0;
         end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            inc_q   <= inc_d;
            dcnt_q  <= dcnt_d;
            done_q  <= done_d;
         end
      end

      assign p = acc_q[ACC_W-1 -: DATA_W];

      always_comb begin
         case (mode_q)
            2'd0:    wave_d = p;
            2'd1:    wave_d = p[DATA_W-1] ? ~{p[DATA_W-2:0], 1'b0} : {p[DATA_W-2:0], 1'b0};
            2'd2:    wave_d = {DATA_W{p[DATA_W-1]}};
            default: wave_d = MID;
         endcase
      end

      // out = mid + floor((w - mid) * ampl / 2^DATA_W) (+ dither), clamped.
      always_comb begin
         s    = $signed({1'b0, wave_q}) - $signed({1'b0, MID});
         prod = PW'(s) * PW'($signed({1'b0, ampl_q}));
         tot  = (prod >>> DATA_W) + $signed({{(PW-DATA_W){1'b0}}, MID})
                + $signed({{(PW-1){1'b0}}, dith});
         if (tot[PW-1])               out_d = '0;
         else if (|tot[PW-2:DATA_W])  out_d = '1;
         else                         out_d = tot[DATA_W-1:0];
      end

      // act_q travels with wave_q so a freshly started channel never shows
      // a stale waveform sample.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            wave_q <= '0;
            act_q  <= 1'b0;
            data_q <= MID;
         end else begin
            wave_q <= wave_d;
            act_q  <= (state_q != ST_IDLE);
            data_q <= (act_q && !gate) ? out_d : MID;
         end
      end

      assign data[n*DATA_W +: DATA_W] = data_q;
      assign running[n]               = (state_q != ST_IDLE);
      assign sweep_done[n]            = done_q;
      assign state_dbg[2*n +: 2]      = state_q;
   end

endmodule
